// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: stalls the pipeline
// while a single aligned load/store is handed to an external memory.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] access_cnt_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] access_cnt_q, access_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic req;
    logic aligned;
    logic stall;

    assign req     = MemRead_i | MemWrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wait_d       = wait_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        access_cnt_d = access_cnt_q;
        stall        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req && aligned) begin
                    stall       = 1'b1;
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite_i;
                    mem_addr_d  = {addr_i[31:2], 2'b00};
                    mem_wdata_d = data_i;
                    wait_d      = 8'd0;
                end else if (req) begin
                    err_d = 1'b1;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    rdata_d      = mem_we_q ? 32'd0 : mem_rdata_i;
                    access_cnt_d = access_cnt_q + 32'd1;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == TMO_LAST) begin
                        state_d   = DONE;
                        mem_req_d = 1'b0;
                        rdata_d   = 32'd0;
                        err_d     = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // reset forces the pipeline free even mid-access
        if (rst_i) begin
            stall = 1'b0;
        end
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            wait_q       <= 8'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            access_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wait_q       <= wait_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            access_cnt_q <= access_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign data_o       = (state_q == DONE) ? rdata_q : 32'd0;
    assign stall_o      = stall;
    assign err_o        = err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign access_cnt_o = access_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bench for mem_access_ctrl against a
// transaction-level model of latency, data, error and counters.
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] access_cnt_o;
    logic [31:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;
    int mon_stall = 0;
    logic [31:0] m_acc = 0;
    logic [31:0] m_stl = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .access_cnt_o (access_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (stall_o === 1'b1) mon_stall = mon_stall + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One memory instruction from IDLE back to IDLE; dly = REQ cycles
    // without ack before the acknowledge (dly >= TMO never acks).
    task automatic access(input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, input logic [31:0] rdata);
        bit aligned;
        bit tmo;
        int nreq;
        int mon0;
        logic [31:0] exp_data;
        aligned = (addr[1:0] == 2'b00);
        tmo = (dly >= TMO);
        nreq = tmo ? TMO : dly + 1;
        exp_data = (tmo || wr) ? 32'd0 : rdata;
        mon0 = mon_stall;
        MemRead_i = rd;
        MemWrite_i = wr;
        addr_i = addr;
        data_i = wd;
        @(negedge clk_i);
        chk("detect_stall", {31'd0, stall_o}, {31'd0, aligned});
        chk("detect_req", {31'd0, mem_req_o}, 32'd0);
        chk("detect_data", data_o, 32'd0);
        tick();
        MemRead_i = 1'b0;
        MemWrite_i = 1'b0;
        addr_i = $urandom;
        if (!aligned) begin
            @(negedge clk_i);
            chk("mis_err", {31'd0, err_o}, 32'd1);
            chk("mis_req", {31'd0, mem_req_o}, 32'd0);
            chk("mis_stall", {31'd0, stall_o}, 32'd0);
            chk("mis_data", data_o, 32'd0);
            tick();
            @(negedge clk_i);
            chk("mis_err_once", {31'd0, err_o}, 32'd0);
            chk("mis_acc", access_cnt_o, m_acc);
            tick();
            return;
        end
        for (int n = 0; n < nreq; n++) begin
            mem_ack_i = (!tmo && n == dly);
            mem_rdata_i = mem_ack_i ? rdata : $urandom;
            @(negedge clk_i);
            chk("req_req", {31'd0, mem_req_o}, 32'd1);
            chk("req_stall", {31'd0, stall_o}, 32'd1);
            chk("req_we", {31'd0, mem_we_o}, {31'd0, wr});
            chk("req_addr", mem_addr_o, addr);
            chk("req_wdata", mem_wdata_o, wd);
            chk("req_data", data_o, 32'd0);
            tick();
        end
        if (!tmo) m_acc = m_acc + 1;
        m_stl = m_stl + 32'(nreq + 1);
        mem_ack_i = 1'b1;
        mem_rdata_i = $urandom;
        @(negedge clk_i);
        chk("done_stall", {31'd0, stall_o}, 32'd0);
        chk("done_req", {31'd0, mem_req_o}, 32'd0);
        chk("done_data", data_o, exp_data);
        chk("done_err", {31'd0, err_o}, {31'd0, tmo});
        chk("done_acc", access_cnt_o, m_acc);
        chk("done_stl", stall_cnt_o, m_stl);
        chk("stall_len", 32'(mon_stall - mon0), 32'(nreq + 1));
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("idle_data", data_o, 32'd0);
        chk("idle_err", {31'd0, err_o}, 32'd0);
        chk("idle_req", {31'd0, mem_req_o}, 32'd0);
        chk("idle_acc", access_cnt_o, m_acc);
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        MemRead_i = 1'b1;
        MemWrite_i = 1'b0;
        addr_i = 32'h40;
        data_i = 32'd0;
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'd0;
        @(negedge clk_i);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        tick();
        @(negedge clk_i);
        chk("rst_stall2", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_acc", access_cnt_o, 32'd0);
        chk("rst_stl", stall_cnt_o, 32'd0);
        MemRead_i = 1'b0;
        tick();
        rst_i = 1'b0;
        mon_stall = 0;
        tick();

        access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'h20, 32'h12345678, 0, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h0);
        access(1'b1, 1'b0, 32'h30, 32'h0, 99, 32'h55AA55AA);
        access(1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 2, 32'h11111111);
        access(1'b1, 1'b0, 32'h48, 32'h0, TMO - 1, 32'h87654321);

        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            else if (a[1:0] == 2'b00) a[0] = 1'b1;
            access(kind != 1, kind != 0, a, $urandom,
                   $urandom_range(0, TMO + 1), $urandom);
        end

        MemRead_i = 1'b1;
        addr_i = 32'h80;
        tick();
        MemRead_i = 1'b0;
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h99999999;
        @(negedge clk_i);
        chk("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("mid_rst_acc", access_cnt_o, 32'd0);
        chk("mid_rst_stl", stall_cnt_o, 32'd0);
        chk("mid_rst_data", data_o, 32'd0);
        chk("mid_rst_stall2", {31'd0, stall_o}, 32'd0);
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_acc", access_cnt_o, 32'd0);
        chk("late_ack_req", {31'd0, mem_req_o}, 32'd0);
        chk("late_ack_data", data_o, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
